// File: rtl/ntt_seq.sv
// Sequencer for one NTT-core polynomial operation: steps mode/clk_counter through
// the read schedule, inserts inter-stage gaps, and aligns write strobes to the pipeline.
module ntt_seq #(
  parameter int unsigned BF_LAT     = 10,
  parameter int unsigned MULT_LAT   = 18,
  parameter int unsigned ADDSUB_LAT = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  output logic [1:0] mode,
  output logic [7:0] clk_counter,
  output logic       rd_en,
  output logic       wr_en,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MAX_BM  = (BF_LAT > MULT_LAT) ? BF_LAT : MULT_LAT;
  localparam int unsigned MAX_LAT = (MAX_BM > ADDSUB_LAT) ? MAX_BM : ADDSUB_LAT;
  localparam int unsigned LAT_W   = $clog2(MAX_LAT + 1);
  localparam int unsigned SR_W    = MAX_LAT - 1;
  localparam int unsigned TAP_W   = $clog2(SR_W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [LAT_W-1:0] lat_cnt, lat_cnt_nxt;
  logic [SR_W-1:0]  rd_sr, rd_sr_nxt;
  logic [1:0]       mode_nxt;
  logic [7:0]       cnt_nxt;
  logic             rd_nxt, wr_nxt, busy_nxt, done_nxt;

  logic             is_ntt;
  logic [7:0]       last_cnt;
  logic [LAT_W-1:0] act_lat_m1;
  logic [TAP_W-1:0] tap;

  // Per-operation schedule length and latency; wr_en tap is latency-2 because wr_en is itself a flop
  always_comb begin
    is_ntt     = ~mode[1];
    last_cnt   = 8'd223;
    act_lat_m1 = LAT_W'(BF_LAT - 1);
    tap        = TAP_W'(BF_LAT - 2);
    case (mode)
      2'd2: begin
        last_cnt   = 8'd127;
        act_lat_m1 = LAT_W'(MULT_LAT - 1);
        tap        = TAP_W'(MULT_LAT - 2);
      end
      2'd3: begin
        last_cnt   = 8'd63;
        act_lat_m1 = LAT_W'(ADDSUB_LAT - 1);
        tap        = TAP_W'(ADDSUB_LAT - 2);
      end
      default: ;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    mode_nxt    = mode;
    cnt_nxt     = clk_counter;
    rd_nxt      = 1'b0;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    rd_sr_nxt   = {rd_sr[SR_W-2:0], rd_en};
    wr_nxt      = rd_sr[tap];

    case (state)
      S_IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          state_nxt = S_RUN;
          mode_nxt  = op;
          cnt_nxt   = 8'd0;
          rd_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          rd_sr_nxt = '0;
          wr_nxt    = 1'b0;
        end
      end
      S_RUN: begin
        if (clk_counter == last_cnt) begin
          state_nxt   = S_DRAIN;
          lat_cnt_nxt = act_lat_m1;
          if (!is_ntt) cnt_nxt = clk_counter + 8'd1;
        end else if (is_ntt && clk_counter[4:0] == 5'd31 && clk_counter[7:5] < 3'd6) begin
          state_nxt   = S_GAP;
          lat_cnt_nxt = LAT_W'(BF_LAT - 1);
        end else begin
          rd_nxt  = 1'b1;
          cnt_nxt = clk_counter + 8'd1;
        end
      end
      S_GAP: begin
        if (lat_cnt == '0) begin
          state_nxt = S_RUN;
          rd_nxt    = 1'b1;
          cnt_nxt   = clk_counter + 8'd1;
        end else begin
          lat_cnt_nxt = lat_cnt - LAT_W'(1);
        end
      end
      S_DRAIN: begin
        if (lat_cnt == '0) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          lat_cnt_nxt = lat_cnt - LAT_W'(1);
          if (!is_ntt) cnt_nxt = clk_counter + 8'd1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lat_cnt     <= '0;
      rd_sr       <= '0;
      mode        <= 2'd0;
      clk_counter <= 8'd0;
      rd_en       <= 1'b0;
      wr_en       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      lat_cnt     <= lat_cnt_nxt;
      rd_sr       <= rd_sr_nxt;
      mode        <= mode_nxt;
      clk_counter <= cnt_nxt;
      rd_en       <= rd_nxt;
      wr_en       <= wr_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_ntt_seq.sv
// Bench for ntt_seq: per-cycle comparison against a schedule model built from the
// operation rules, with random start/op noise while busy and a mid-run reset.
module tb_ntt_seq;

  localparam int unsigned BF_LAT     = 10;
  localparam int unsigned MULT_LAT   = 18;
  localparam int unsigned ADDSUB_LAT = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] op;
  logic [1:0] mode;
  logic [7:0] clk_counter;
  logic       rd_en, wr_en, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  int e_rd[$], e_wr[$], e_cnt[$], e_busy[$], e_done[$];

  ntt_seq #(
    .BF_LAT(BF_LAT),
    .MULT_LAT(MULT_LAT),
    .ADDSUB_LAT(ADDSUB_LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .op(op),
    .mode(mode),
    .clk_counter(clk_counter),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected per-cycle schedule; index = cycle after the accepting edge (0 unused)
  task automatic build_model(input int opc);
    int lat, n, last;
    e_rd.delete(); e_wr.delete(); e_cnt.delete(); e_busy.delete(); e_done.delete();
    lat = (opc < 2) ? BF_LAT : (opc == 2) ? MULT_LAT : ADDSUB_LAT;
    e_rd.push_back(0); e_cnt.push_back(0);
    if (opc < 2) begin
      for (int s = 0; s < 7; s++) begin
        for (int i = 0; i < 32; i++) begin
          e_rd.push_back(1); e_cnt.push_back(32 * s + i);
        end
        if (s < 6)
          for (int g = 0; g < BF_LAT; g++) begin
            e_rd.push_back(0); e_cnt.push_back(32 * s + 31);
          end
      end
    end else begin
      n = (opc == 2) ? 128 : 64;
      for (int i = 0; i < n; i++) begin
        e_rd.push_back(1); e_cnt.push_back(i);
      end
    end
    last = e_cnt[e_cnt.size() - 1];
    for (int d = 0; d < lat; d++) begin
      e_rd.push_back(0);
      e_cnt.push_back((opc < 2) ? last : last + 1 + d);
    end
    e_rd.push_back(0);
    e_cnt.push_back(e_cnt[e_cnt.size() - 1]);
    for (int t = 0; t < e_rd.size(); t++) begin
      e_wr.push_back((t >= lat) ? e_rd[t - lat] : 0);
      e_busy.push_back((t >= 1 && t < e_rd.size() - 1) ? 1 : 0);
      e_done.push_back((t == e_rd.size() - 1) ? 1 : 0);
    end
  endtask

  // Start at a negedge; returns at the negedge of the first IDLE cycle after DONE
  task automatic run_op(input int opc, input bit hold, input bit noise);
    int tend, nrd, nwr, erd, ewr;
    nrd = 0; nwr = 0; erd = 0; ewr = 0;
    build_model(opc);
    tend = e_rd.size() - 1;
    start = 1'b1;
    op = 2'(opc);
    @(posedge clk);
    @(negedge clk);
    for (int t = 1; t <= tend; t++) begin
      check($sformatf("op%0d c%0d rd_en", opc, t), int'(rd_en), e_rd[t]);
      check($sformatf("op%0d c%0d wr_en", opc, t), int'(wr_en), e_wr[t]);
      check($sformatf("op%0d c%0d clk_counter", opc, t), int'(clk_counter), e_cnt[t]);
      check($sformatf("op%0d c%0d busy", opc, t), int'(busy), e_busy[t]);
      check($sformatf("op%0d c%0d done", opc, t), int'(done), e_done[t]);
      check($sformatf("op%0d c%0d mode", opc, t), int'(mode), opc);
      nrd += int'(rd_en); nwr += int'(wr_en);
      erd += e_rd[t];     ewr += e_wr[t];
      if (!hold) begin
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        op    = 2'($urandom);
      end
      @(negedge clk);
    end
    check($sformatf("op%0d idle busy", opc), int'(busy), 0);
    check($sformatf("op%0d idle rd_en", opc), int'(rd_en), 0);
    check($sformatf("op%0d idle wr_en", opc), int'(wr_en), 0);
    check($sformatf("op%0d idle done", opc), int'(done), 0);
    check($sformatf("op%0d idle clk_counter", opc), int'(clk_counter), e_cnt[tend]);
    check($sformatf("op%0d idle mode", opc), int'(mode), opc);
    check($sformatf("op%0d read count", opc), nrd, erd);
    check($sformatf("op%0d write count", opc), nwr, ewr);
    check($sformatf("op%0d writes eq reads", opc), nwr, nrd);
    if (!hold) start = 1'b0;
  endtask

  task automatic reset_mid_run();
    build_model(0);
    start = 1'b1;
    op = 2'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t <= 131; t++) begin
      check($sformatf("rst c%0d clk_counter", t), int'(clk_counter), e_cnt[t]);
      check($sformatf("rst c%0d rd_en", t), int'(rd_en), e_rd[t]);
      if (t < 131) @(negedge clk);
    end
    rst_n = 1'b0;
    start = 1'b1;
    op    = 2'($urandom);
    @(negedge clk);
    check("rst mode", int'(mode), 0);
    check("rst clk_counter", int'(clk_counter), 0);
    check("rst rd_en", int'(rd_en), 0);
    check("rst wr_en", int'(wr_en), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      check($sformatf("post-rst %0d wr_en", t), int'(wr_en), 0);
      check($sformatf("post-rst %0d rd_en", t), int'(rd_en), 0);
      check($sformatf("post-rst %0d busy", t), int'(busy), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    op    = 2'd2;
    repeat (3) @(negedge clk);
    check("init mode", int'(mode), 0);
    check("init clk_counter", int'(clk_counter), 0);
    check("init rd_en", int'(rd_en), 0);
    check("init wr_en", int'(wr_en), 0);
    check("init busy", int'(busy), 0);
    check("init done", int'(done), 0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);

    run_op(0, 1'b0, 1'b0);
    run_op(1, 1'b0, 1'b1);
    run_op(2, 1'b0, 1'b1);
    run_op(3, 1'b0, 1'b1);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    run_op(3, 1'b1, 1'b0);
    run_op(3, 1'b1, 1'b0);
    start = 1'b0;
    @(negedge clk);
    reset_mid_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
